// File: rtl/mil_std_rcv_decoder.sv
// MIL-STD-1553 Manchester II receive decoder: sync detection, 16-bit deserialisation, odd parity.
// Define MIL_STD_RCV_GLITCH_FILTER_EN to add a 3-sample majority filter after the synchroniser.
module mil_std_rcv_decoder #(
   parameter int CLKS_PER_BIT = 50,
   parameter int SYNC_TOL     = 6
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rcv_en_i,
   input  logic        rx_p_i,
   input  logic        rx_n_i,
   output logic        busy_o,
   output logic        word_valid_o,
   output logic [15:0] data_o,
   output logic        sync_c_o,
   output logic        parity_err_o,
   output logic        manch_err_o
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int RW = $clog2(4 * CLKS_PER_BIT);

   localparam logic [RW-1:0] SYNC_MIN = RW'(3 * H - SYNC_TOL);
   localparam logic [RW-1:0] SYNC_MAX = RW'(3 * H + SYNC_TOL);
   localparam logic [RW-1:0] T_SYNC2  = RW'(3 * H - 1);
   localparam logic [RW-1:0] T_SMP1   = RW'(H / 2);
   localparam logic [RW-1:0] T_SMP2   = RW'((3 * H) / 2);
   localparam logic [RW-1:0] T_MID    = RW'(H);
   localparam logic [RW-1:0] T_END    = RW'(CLKS_PER_BIT - 1);
   localparam logic [RW-1:0] RUN_MAX  = '1;

   typedef enum logic [1:0] {LV_NULL = 2'd0, LV_HI = 2'd1, LV_LO = 2'd2} level_t;
   typedef enum logic [2:0] {S_IDLE, S_SYNC_1ST, S_SYNC_2ND, S_DATA, S_PARITY} state_t;

   // Reset asserts asynchronously but releases on a clock edge.
   logic [1:0] rst_sh;
   logic       arst;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rst_sh <= 2'b11;
      else       rst_sh <= {rst_sh[0], 1'b0};
   end

   assign arst = rst_sh[1];

   logic [1:0] p_sync, n_sync;
   logic       p_line, n_line;

   always_ff @(posedge clk_i or posedge arst) begin
      if (arst) begin
         p_sync <= '0;
         n_sync <= '0;
      end else begin
         p_sync <= {p_sync[0], rx_p_i};
         n_sync <= {n_sync[0], rx_n_i};
      end
   end

`ifdef MIL_STD_RCV_GLITCH_FILTER_EN
   logic [1:0] p_hist, n_hist;

   always_ff @(posedge clk_i or posedge arst) begin
      if (arst) begin
         p_hist <= '0;
         n_hist <= '0;
      end else begin
         p_hist <= {p_hist[0], p_sync[1]};
         n_hist <= {n_hist[0], n_sync[1]};
      end
   end

   assign p_line = (p_sync[1] & p_hist[0]) | (p_sync[1] & p_hist[1]) | (p_hist[0] & p_hist[1]);
   assign n_line = (n_sync[1] & n_hist[0]) | (n_sync[1] & n_hist[1]) | (n_hist[0] & n_hist[1]);
`else
   assign p_line = p_sync[1];
   assign n_line = n_sync[1];
`endif

   level_t lvl, lvl_q, h1;
   logic   edge_det;
   logic [RW-1:0] run;

   always_comb begin
      lvl = LV_NULL;
      if (p_line && !n_line)      lvl = LV_HI;
      else if (!p_line && n_line) lvl = LV_LO;
   end

   assign edge_det = (lvl != lvl_q);

   // run = cycles the previous level lasted, valid in the cycle the level changes.
   always_ff @(posedge clk_i or posedge arst) begin
      if (arst) begin
         lvl_q <= LV_NULL;
         run   <= '0;
      end else begin
         lvl_q <= lvl;
         if (edge_det)            run <= RW'(1);
         else if (run != RUN_MAX) run <= run + 1'b1;
      end
   end

   state_t        state, state_d;
   logic [RW-1:0] tmr;
   logic [4:0]    bitk;
   logic [15:0]   shreg;
   logic          sync_c_q;
   logic          sync_ok, in_bit, smp2, anchor, bit_ok, bit_one;
   logic          word_done, manch_fail;

   assign sync_ok = (run >= SYNC_MIN) && (run <= SYNC_MAX);
   assign in_bit  = (state == S_DATA) || (state == S_PARITY);
   assign smp2    = in_bit && (tmr == T_SMP2);
   assign anchor  = in_bit && edge_det && (tmr > T_SMP1) && (tmr < T_SMP2);
   assign bit_ok  = ((h1 == LV_HI) && (lvl == LV_LO)) || ((h1 == LV_LO) && (lvl == LV_HI));
   assign bit_one = (h1 == LV_HI);
   assign busy_o  = (state == S_SYNC_2ND) || in_bit;

   always_ff @(posedge clk_i or posedge arst) begin
      if (arst) state <= S_IDLE;
      else      state <= state_d;
   end

   always_comb begin
      state_d    = state;
      word_done  = 1'b0;
      manch_fail = 1'b0;
      unique case (state)
         // word_valid_o marks the cycle after a word: the level left on the line starts a new run.
         S_IDLE:
            if (lvl != LV_NULL && (edge_det || word_valid_o)) state_d = S_SYNC_1ST;
         S_SYNC_1ST:
            if (edge_det) begin
               if (sync_ok)             state_d = S_SYNC_2ND;
               else if (lvl == LV_NULL) state_d = S_IDLE;
            end
         S_SYNC_2ND:
            if (tmr == T_SYNC2) state_d = S_DATA;
         S_DATA:
            if (smp2 && !bit_ok) begin
               manch_fail = 1'b1;
               state_d    = S_IDLE;
            end else if (tmr == T_END && bitk == 5'd15) begin
               state_d = S_PARITY;
            end
         S_PARITY:
            if (smp2) begin
               word_done  = bit_ok;
               manch_fail = !bit_ok;
               state_d    = S_IDLE;
            end
         default: state_d = S_IDLE;
      endcase
      if (!rcv_en_i) begin
         state_d    = S_IDLE;
         word_done  = 1'b0;
         manch_fail = 1'b0;
      end
   end

   // tmr counts cycles since t0 in SYNC_2ND, then cycles since bit start.
   always_ff @(posedge clk_i or posedge arst) begin
      if (arst) begin
         tmr      <= '0;
         bitk     <= '0;
         h1       <= LV_NULL;
         shreg    <= '0;
         sync_c_q <= 1'b0;
      end else begin
         unique case (state)
            S_SYNC_1ST:       tmr <= RW'(1);
            S_SYNC_2ND:       tmr <= (tmr == T_SYNC2) ? '0 : tmr + 1'b1;
            S_DATA, S_PARITY: tmr <= anchor ? T_MID + 1'b1 : ((tmr == T_END) ? '0 : tmr + 1'b1);
            default:          tmr <= '0;
         endcase
         if (state == S_SYNC_2ND)               bitk <= '0;
         else if (in_bit && tmr == T_END)       bitk <= bitk + 1'b1;
         if (in_bit && tmr == T_SMP1)           h1 <= lvl;
         if (state == S_DATA && tmr == T_SMP2)  shreg <= {shreg[14:0], bit_one};
         if (state == S_SYNC_1ST && edge_det && sync_ok) sync_c_q <= (lvl_q == LV_HI);
      end
   end

   always_ff @(posedge clk_i or posedge arst) begin
      if (arst) begin
         word_valid_o <= 1'b0;
         manch_err_o  <= 1'b0;
         data_o       <= '0;
         sync_c_o     <= 1'b0;
         parity_err_o <= 1'b0;
      end else begin
         word_valid_o <= word_done;
         manch_err_o  <= manch_fail;
         if (word_done) begin
            data_o       <= shreg;
            sync_c_o     <= sync_c_q;
            parity_err_o <= ~^{shreg, bit_one};
         end
      end
   end

endmodule

// File: tb/tb_mil_std_rcv_decoder.sv
// Bench for mil_std_rcv_decoder: directed scenarios plus random words checked against
// expected word/sync/parity values derived from the 1553 word rules.
module tb_mil_std_rcv_decoder;

   localparam logic [1:0] LN = 2'b00, LH = 2'b10, LL = 2'b01;  // {p, n}

   logic        clk = 1'b0, rst = 1'b1, rcv_en = 1'b1, rx_p = 1'b0, rx_n = 1'b0;
   logic        busy, word_valid, sync_c, parity_err, manch_err;
   logic [15:0] data;

   int n_chk = 0, n_pass = 0;
   int wv_n = 0, me_n = 0, both_n = 0, busy_n = 0;
   logic [15:0] last_data = '0;

   mil_std_rcv_decoder #(.CLKS_PER_BIT(50), .SYNC_TOL(6)) dut (
      .clk_i(clk), .rst_i(rst), .rcv_en_i(rcv_en), .rx_p_i(rx_p), .rx_n_i(rx_n),
      .busy_o(busy), .word_valid_o(word_valid), .data_o(data), .sync_c_o(sync_c),
      .parity_err_o(parity_err), .manch_err_o(manch_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (word_valid) wv_n++;
      if (manch_err) me_n++;
      if (word_valid && manch_err) both_n++;
      if (busy) busy_n++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   task automatic drv(input logic [1:0] l, input int n);
      {rx_p, rx_n} = l;
      repeat (n) @(negedge clk);
   endtask

   // cut_kind: 1 = drop enable, 2 = pulse reset, at the start of bit cut.
   task automatic send(input bit cmd, input logic [15:0] d, input bit p, input int s1,
                       input int bad, input int cut, input int cut_kind, input int gap);
      logic [16:0] bits;
      logic [1:0]  ha, hb;
      bits = {d, p};
      drv(cmd ? LH : LL, s1);
      drv(cmd ? LL : LH, 75);
      for (int k = 0; k < 17; k++) begin
         ha = bits[16-k] ? LH : LL;
         hb = bits[16-k] ? LL : LH;
         if (k == bad) hb = ha;
         if (k == cut) begin
            chk("busy_mid", busy, 1);
            {rx_p, rx_n} = ha;
            if (cut_kind == 1) begin
               rcv_en = 1'b0;
               @(negedge clk);
               chk("busy_off", busy, 0);
               drv(ha, 24);
            end else begin
               rst = 1'b1;
               #1;
               chk("rst_outs", {busy, word_valid, manch_err, sync_c, parity_err, data}, 0);
               @(negedge clk);
               drv(ha, 2);
               rst = 1'b0;
               drv(ha, 22);
            end
            drv(hb, 25);
         end else begin
            drv(ha, 25);
            drv(hb, 25);
         end
      end
      drv(LN, gap);
   endtask

   task automatic expect_word(input string tag, input int wv0, input int me0,
                              input bit cmd, input logic [15:0] d, input bit p);
      chk({tag, "_wv"}, wv_n - wv0, 1);
      chk({tag, "_me"}, me_n - me0, 0);
      chk({tag, "_data"}, data, d);
      chk({tag, "_sync"}, sync_c, cmd);
      chk({tag, "_perr"}, parity_err, ($countones({d, p}) % 2) == 0);
      last_data = d;
   endtask

   task automatic expect_none(input string tag, input int wv0, input int me0, input int me_exp);
      chk({tag, "_wv"}, wv_n - wv0, 0);
      chk({tag, "_me"}, me_n - me0, me_exp);
      chk({tag, "_data"}, data, last_data);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int wv0, me0, b0, s1, bad, gap;
      bit cmd, p;
      logic [15:0] d;

      drv(LN, 4);
      chk("reset", {busy, word_valid, manch_err, sync_c, parity_err, data}, 0);
      rst = 1'b0;
      drv(LN, 10);

      wv0 = wv_n; me0 = me_n;
      send(1, 16'hA5A5, 1, 75, -1, -1, 0, 40);
      expect_word("t1", wv0, me0, 1, 16'hA5A5, 1);

      wv0 = wv_n; me0 = me_n;
      send(0, 16'h0001, 1, 75, -1, -1, 0, 40);
      expect_word("t2", wv0, me0, 0, 16'h0001, 1);

      wv0 = wv_n; me0 = me_n;
      send(1, 16'hBEEF, ~^16'hBEEF, 75, 5, -1, 0, 40);
      expect_none("t3_bad", wv0, me0, 1);
      wv0 = wv_n; me0 = me_n;
      send(1, 16'h1234, ~^16'h1234, 75, -1, -1, 0, 40);
      expect_word("t3_good", wv0, me0, 1, 16'h1234, ~^16'h1234);

      wv0 = wv_n; me0 = me_n; b0 = busy_n;
      drv(LH, 100);
      drv(LN, 60);
      chk("t4_busy_cycles", busy_n - b0, 0);
      expect_none("t4_long", wv0, me0, 0);
      wv0 = wv_n; me0 = me_n;
      send(1, 16'h5A3C, ~^16'h5A3C, 70, -1, -1, 0, 40);
      expect_word("t4_70", wv0, me0, 1, 16'h5A3C, ~^16'h5A3C);
      wv0 = wv_n; me0 = me_n;
      send(0, 16'hC001, ~^16'hC001, 80, -1, -1, 0, 40);
      expect_word("t4_80", wv0, me0, 0, 16'hC001, ~^16'hC001);

      wv0 = wv_n; me0 = me_n;
      send(1, 16'h7E81, ~^16'h7E81, 75, -1, 8, 1, 40);
      expect_none("t5_drop", wv0, me0, 0);
      rcv_en = 1'b1;
      drv(LN, 10);
      wv0 = wv_n; me0 = me_n;
      send(0, 16'h0F0F, ~^16'h0F0F, 75, -1, -1, 0, 40);
      expect_word("t5_after", wv0, me0, 0, 16'h0F0F, ~^16'h0F0F);

      send(1, 16'h3333, ~^16'h3333, 75, -1, 8, 2, 40);
      last_data = '0;
      wv0 = wv_n; me0 = me_n;
      send(1, 16'hFFFF, 1, 75, -1, -1, 0, 40);
      expect_word("t6_ffff", wv0, me0, 1, 16'hFFFF, 1);

      for (int i = 0; i < 20; i++) begin
         cmd = 1'($urandom_range(0, 1));
         d   = 16'($urandom);
         p   = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : ~^d;
         s1  = $urandom_range(70, 80);
         bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 16) : -1;
         gap = $urandom_range(30, 80);
         wv0 = wv_n; me0 = me_n;
         send(cmd, d, p, s1, bad, -1, 0, gap);
         if (bad >= 0) expect_none("rnd_bad", wv0, me0, 1);
         else          expect_word("rnd", wv0, me0, cmd, d, p);
      end

      chk("strobe_overlap", both_n, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
